// File: rtl/lpif_tx_fifo.sv
// LPIF transmit beat buffer: FWFT FIFO between the link-layer TX port and MAC framing,
// with per-byte TLP framing check, completed-TLP counter and flush on link not Active.
module lpif_tx_fifo #(
  parameter int         NBYTES      = 64,
  parameter int         DEPTH       = 8,
  parameter logic [3:0] ACTIVE_CODE = 4'h1
) (
  input  logic                      CLK,
  input  logic                      lpreset,
  input  logic [3:0]                pl_state_sts,
  input  logic                      lp_irdy,
  input  logic [8*NBYTES-1:0]       lp_data,
  input  logic [NBYTES-1:0]         lp_valid,
  input  logic [NBYTES-1:0]         lp_tlpstart,
  input  logic [NBYTES-1:0]         lp_tlpend,
  input  logic [NBYTES-1:0]         lp_dlpstart,
  input  logic [NBYTES-1:0]         lp_dlpend,
  output logic                      pl_trdy,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [8*NBYTES-1:0]       tx_data,
  output logic [NBYTES-1:0]         tx_valid_bytes,
  output logic [NBYTES-1:0]         tx_tlpstart,
  output logic [NBYTES-1:0]         tx_tlpend,
  output logic [NBYTES-1:0]         tx_dlpstart,
  output logic [NBYTES-1:0]         tx_dlpend,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      tlp_in_flight,
  output logic                      framing_err,
  output logic [15:0]               tlp_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DW    = 8 * NBYTES;
  localparam int ENT_W = DW + 5 * NBYTES;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             r_tlp_in_flight;
  logic             r_framing_err;
  logic [15:0]      r_tlp_count;

  logic             w_active;
  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic [NBYTES-1:0] w_marks;
  logic             w_open;
  logic             w_err;
  logic [15:0]      w_done;
  logic [ENT_W-1:0] w_head;

  assign w_active = (pl_state_sts == ACTIVE_CODE);
  assign pl_trdy  = w_active && !lpreset && (r_count < LVL_W'(DEPTH));
  assign w_push   = lp_irdy && pl_trdy;
  // Idle beats (no valid bytes) are accepted but never occupy an entry.
  assign w_store  = w_push && (lp_valid != '0);
  assign tx_valid = (r_count != '0);
  assign w_pop    = tx_valid && tx_ready;
  assign w_marks  = lp_tlpstart | lp_tlpend | lp_dlpstart | lp_dlpend;

  // Byte-serial framing scan, carrying the open-TLP state in from the previous beat.
  always_comb begin
    w_open = r_tlp_in_flight;
    w_err  = 1'b0;
    w_done = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (!lp_valid[i] && w_marks[i]) w_err = 1'b1;
      if (lp_tlpstart[i] && lp_tlpend[i]) begin
        w_err = 1'b1;
      end else if (lp_tlpstart[i]) begin
        if (w_open) w_err = 1'b1;
        w_open = 1'b1;
      end else if (lp_tlpend[i]) begin
        if (w_open) begin
          w_open = 1'b0;
          w_done = w_done + 16'd1;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (lpreset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_tlp_in_flight <= 1'b0;
      r_framing_err   <= 1'b0;
      r_tlp_count     <= '0;
    end else if (!w_active) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_tlp_in_flight <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push) begin
        r_tlp_in_flight <= w_open;
        r_framing_err   <= r_framing_err | w_err;
        r_tlp_count     <= r_tlp_count + w_done;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_store)
      r_mem[r_wr_ptr] <= {lp_dlpend, lp_dlpstart, lp_tlpend, lp_tlpstart, lp_valid, lp_data};
  end

  assign w_head = r_mem[r_rd_ptr];

  // Head fields are forced to zero while empty so nothing uninitialised leaks out.
  assign tx_data        = tx_valid ? w_head[DW-1:0] : '0;
  assign tx_valid_bytes = tx_valid ? w_head[DW +: NBYTES] : '0;
  assign tx_tlpstart    = tx_valid ? w_head[DW + NBYTES +: NBYTES] : '0;
  assign tx_tlpend      = tx_valid ? w_head[DW + 2*NBYTES +: NBYTES] : '0;
  assign tx_dlpstart    = tx_valid ? w_head[DW + 3*NBYTES +: NBYTES] : '0;
  assign tx_dlpend      = tx_valid ? w_head[DW + 4*NBYTES +: NBYTES] : '0;

  assign fifo_level    = r_count;
  assign tlp_in_flight = r_tlp_in_flight;
  assign framing_err   = r_framing_err;
  assign tlp_count     = r_tlp_count;

endmodule

// File: tb/tb_lpif_tx_fifo.sv
// Randomised and directed checks of lpif_tx_fifo against a queue-based reference model.
module tb_lpif_tx_fifo;
  localparam int         NB    = 64;
  localparam int         DEPTH = 8;
  localparam logic [3:0] ACT   = 4'h1;
  localparam logic [NB-1:0] ONES = '1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            lpreset;
  logic [3:0]      pl_state_sts;
  logic            lp_irdy;
  logic [8*NB-1:0] lp_data;
  logic [NB-1:0]   lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;
  logic            pl_trdy, tx_valid, tx_ready;
  logic [8*NB-1:0] tx_data;
  logic [NB-1:0]   tx_valid_bytes, tx_tlpstart, tx_tlpend, tx_dlpstart, tx_dlpend;
  logic [3:0]      fifo_level;
  logic            tlp_in_flight, framing_err;
  logic [15:0]     tlp_count;

  lpif_tx_fifo #(.NBYTES(NB), .DEPTH(DEPTH), .ACTIVE_CODE(ACT)) dut (
    .CLK(CLK), .lpreset(lpreset), .pl_state_sts(pl_state_sts),
    .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
    .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend),
    .lp_dlpstart(lp_dlpstart), .lp_dlpend(lp_dlpend),
    .pl_trdy(pl_trdy), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid_bytes(tx_valid_bytes),
    .tx_tlpstart(tx_tlpstart), .tx_tlpend(tx_tlpend),
    .tx_dlpstart(tx_dlpstart), .tx_dlpend(tx_dlpend),
    .fifo_level(fifo_level), .tlp_in_flight(tlp_in_flight),
    .framing_err(framing_err), .tlp_count(tlp_count)
  );

  typedef struct {
    logic [8*NB-1:0] d;
    logic [NB-1:0]   v, ts, te, ds, de;
  } beat_t;

  beat_t       mq[$];
  bit          m_if, m_err;
  logic [15:0] m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] bit1(input int i);
    logic [NB-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic idle_in();
    lp_irdy = 0; lp_data = '0; lp_valid = '0;
    lp_tlpstart = '0; lp_tlpend = '0; lp_dlpstart = '0; lp_dlpend = '0;
  endtask

  task automatic set_beat(input logic [NB-1:0] v, input logic [NB-1:0] ts, input logic [NB-1:0] te);
    lp_irdy = 1;
    for (int k = 0; k < 16; k++) lp_data[32*k +: 32] = $urandom;
    lp_valid = v; lp_tlpstart = ts; lp_tlpend = te;
    lp_dlpstart = '0; lp_dlpend = '0;
  endtask

  // Compare DUT against the model for the current cycle, then advance both across one edge.
  task automatic step();
    bit    act, trdy;
    beat_t b;
    bit    open;
    int    done;
    #2;
    act  = (pl_state_sts == ACT);
    trdy = act && !lpreset && (mq.size() < DEPTH);
    check("pl_trdy", pl_trdy, trdy);
    check("tx_valid", tx_valid, mq.size() != 0);
    check("fifo_level", fifo_level, mq.size());
    if (mq.size() != 0) begin
      check("tx_data", tx_data, mq[0].d);
      check("tx_valid_bytes", tx_valid_bytes, mq[0].v);
      check("tx_tlpstart", tx_tlpstart, mq[0].ts);
      check("tx_tlpend", tx_tlpend, mq[0].te);
      check("tx_dlpstart", tx_dlpstart, mq[0].ds);
      check("tx_dlpend", tx_dlpend, mq[0].de);
    end
    check("tlp_in_flight", tlp_in_flight, m_if);
    check("framing_err", framing_err, m_err);
    check("tlp_count", tlp_count, m_cnt);
    if (lpreset) begin
      mq.delete(); m_if = 0; m_err = 0; m_cnt = 0;
    end else if (!act) begin
      mq.delete(); m_if = 0;
    end else begin
      if (mq.size() != 0 && tx_ready) void'(mq.pop_front());
      if (lp_irdy && trdy) begin
        open = m_if; done = 0;
        for (int i = 0; i < NB; i++) begin
          if (!lp_valid[i] && (lp_tlpstart[i] || lp_tlpend[i] || lp_dlpstart[i] || lp_dlpend[i]))
            m_err = 1;
          if (lp_tlpstart[i] && lp_tlpend[i]) m_err = 1;
          else if (lp_tlpstart[i]) begin
            if (open) m_err = 1;
            open = 1;
          end else if (lp_tlpend[i]) begin
            if (open) begin open = 0; done++; end
            else m_err = 1;
          end
        end
        m_if  = open;
        m_cnt = m_cnt + 16'(done);
        if (lp_valid != '0) begin
          b.d = lp_data; b.v = lp_valid; b.ts = lp_tlpstart; b.te = lp_tlpend;
          b.ds = lp_dlpstart; b.de = lp_dlpend;
          mq.push_back(b);
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    lpreset = 1; pl_state_sts = ACT; tx_ready = 0;
    idle_in();
    repeat (2) @(posedge CLK);
    #1;
    mq.delete(); m_if = 0; m_err = 0; m_cnt = 0;
    check("rst_tx_data", tx_data, '0);
    check("rst_level", fifo_level, 4'd0);
    step();
    lpreset = 0;

    // Fill to full, then drain in order
    for (int i = 0; i < 8; i++) begin set_beat(ONES, '0, '0); step(); end
    check("full_level", fifo_level, 4'd8);
    check("full_trdy", pl_trdy, 1'b0);
    step();
    idle_in(); tx_ready = 1;
    repeat (8) step();
    check("drained_level", fifo_level, 4'd0);
    tx_ready = 0;

    // Single-beat TLP
    set_beat(ONES, bit1(0), bit1(63)); step();
    idle_in();
    check("ts0_visible", tx_tlpstart[0], 1'b1);
    check("cnt_one", tlp_count, 16'd1);
    check("if_one", tlp_in_flight, 1'b0);
    tx_ready = 1; step(); step();

    // Two beats, two completions, one left open
    set_beat(ONES, bit1(10), '0); step();
    set_beat(ONES, bit1(4) | bit1(30), bit1(3) | bit1(20)); step();
    idle_in();
    check("cnt_three", tlp_count, 16'd3);
    check("if_open", tlp_in_flight, 1'b1);
    check("err_clean", framing_err, 1'b0);
    repeat (3) step();

    // Close, then orphan end -> sticky error until reset
    set_beat(ONES, '0, bit1(40)); step();
    set_beat(ONES, '0, bit1(5)); step();
    idle_in();
    check("err_set", framing_err, 1'b1);
    for (int i = 0; i < 5; i++) begin set_beat(ONES, '0, '0); step(); end
    idle_in();
    check("err_sticky", framing_err, 1'b1);
    lpreset = 1; step(); lpreset = 0;
    check("err_cleared", framing_err, 1'b0);
    check("cnt_cleared", tlp_count, 16'd0);

    // Flush on link leaving Active
    tx_ready = 0;
    set_beat(ONES, bit1(0), '0); step();
    for (int i = 0; i < 4; i++) begin set_beat(ONES, '0, '0); step(); end
    check("pre_flush_level", fifo_level, 4'd5);
    check("pre_flush_if", tlp_in_flight, 1'b1);
    pl_state_sts = 4'h3; tx_ready = 1;
    step();
    pl_state_sts = ACT; idle_in(); tx_ready = 0;
    check("flush_level", fifo_level, 4'd0);
    check("flush_valid", tx_valid, 1'b0);
    check("flush_if", tlp_in_flight, 1'b0);
    check("flush_cnt", tlp_count, 16'd0);

    // Streaming at level 3 across pointer wrap, with one idle beat
    for (int i = 0; i < 3; i++) begin set_beat(ONES, '0, '0); step(); end
    tx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 15) set_beat('0, '0, '0);
      else set_beat(ONES, '0, '0);
      step();
    end
    check("stream_level", fifo_level, 4'd2);
    idle_in();

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [NB-1:0] v, ts, te;
      r = $urandom_range(0, 15);
      v = (r == 0) ? '0 : (r == 1) ? {$urandom, $urandom} : ONES;
      ts = ($urandom_range(0, 3) == 0) ? bit1($urandom_range(0, NB-1)) : '0;
      te = ($urandom_range(0, 3) == 0) ? bit1($urandom_range(0, NB-1)) : '0;
      set_beat(v, ts, te);
      if ($urandom_range(0, 15) == 0) lp_dlpstart = bit1($urandom_range(0, NB-1));
      if ($urandom_range(0, 15) == 0) lp_dlpend = bit1($urandom_range(0, NB-1));
      lp_irdy  = ($urandom_range(0, 3) != 0);
      tx_ready = ($urandom_range(0, 1) != 0);
      pl_state_sts = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 15)) : ACT;
      lpreset = ($urandom_range(0, 199) == 0);
      step();
    end
    lpreset = 0; idle_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
